// File: rtl/free_list_ctrl.sv
// Rename free-list front end: round-robin tag allocation to NUM_REQ requesters
// and a small return queue that merges squash/retire releases back into the free list.
module free_list_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 6,
  parameter int RQ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic                 alloc_stall,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   alloc_valid,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 fl_read,
  input  logic [TAG_WIDTH-1:0] fl_read_tag,
  input  logic                 fl_read_valid,
  input  logic                 retire_valid,
  input  logic [TAG_WIDTH-1:0] retire_tag,
  input  logic                 squash_valid,
  input  logic [TAG_WIDTH-1:0] squash_tag,
  output logic                 ret_ready,
  output logic                 fl_return_valid,
  output logic [TAG_WIDTH-1:0] fl_return_tag,
  input  logic                 fl_full,
  output logic                 drop_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RQ_DEPTH);

  // ---------------- allocation path ----------------
  logic [IW-1:0]      rr_ptr, rr_next;
  logic [NUM_REQ-1:0] eligible;
  logic               found;

  assign eligible = req_valid & {NUM_REQ{~alloc_stall & fl_read_valid & ~rst}};

  // rr_ptr is the highest-priority index; scan cyclically from it.
  always_comb begin
    int idx;
    grant   = '0;
    rr_next = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        rr_next    = (idx == NUM_REQ - 1) ? '0 : IW'(idx + 1);
      end
    end
  end

  assign fl_read = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      alloc_valid <= '0;
    end else begin
      alloc_valid <= grant;
      if (found) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (fl_read) alloc_tag <= fl_read_tag;
  end

  // ---------------- return path ----------------
  logic [TAG_WIDTH-1:0] mem [RQ_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 enq_sq, enq_rt, deq;
  logic [1:0]           enq_n;

  // Two free slots guarantee both ports can land; a same-cycle pop is not credited.
  assign ret_ready       = (DEPTH_C - count) >= CW'(2);
  assign enq_sq          = squash_valid & ret_ready & ~rst;
  assign enq_rt          = retire_valid & ret_ready & ~rst;
  assign enq_n           = {1'b0, enq_sq} + {1'b0, enq_rt};
  assign fl_return_valid = (count != '0) & ~fl_full & ~rst;
  assign fl_return_tag   = mem[rd_ptr];
  assign deq             = fl_return_valid;

  // Squash goes first when both ports release in the same cycle.
  always_ff @(posedge clk) begin
    if (enq_sq) mem[wr_ptr] <= squash_tag;
    if (enq_rt) mem[wr_ptr + PW'(enq_sq)] <= retire_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(enq_n);
      rd_ptr   <= rd_ptr + PW'(deq);
      count    <= count + CW'(enq_n) - CW'(deq);
      drop_err <= drop_err | ((squash_valid | retire_valid) & ~ret_ready);
    end
  end
endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares against what the DUT presents.
module tb_free_list_ctrl;
  localparam int NUM_REQ = 2;
  localparam int TW      = 6;
  localparam int DEPTH   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic          alloc_stall;
  logic [1:0]    grant;
  logic [1:0]    alloc_valid;
  logic [TW-1:0] alloc_tag;
  logic          fl_read;
  logic [TW-1:0] fl_read_tag;
  logic          fl_read_valid;
  logic          retire_valid;
  logic [TW-1:0] retire_tag;
  logic          squash_valid;
  logic [TW-1:0] squash_tag;
  logic          ret_ready;
  logic          fl_return_valid;
  logic [TW-1:0] fl_return_tag;
  logic          fl_full;
  logic          drop_err;

  free_list_ctrl #(.NUM_REQ(NUM_REQ), .TAG_WIDTH(TW), .RQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .alloc_stall(alloc_stall),
    .grant(grant), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .fl_read(fl_read), .fl_read_tag(fl_read_tag), .fl_read_valid(fl_read_valid),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .squash_valid(squash_valid), .squash_tag(squash_tag),
    .ret_ready(ret_ready), .fl_return_valid(fl_return_valid),
    .fl_return_tag(fl_return_tag), .fl_full(fl_full), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] av;
    logic [TW-1:0] tag;
  } alloc_t;

  typedef struct {
    logic [1:0] grant;
    logic       fl_read;
    logic       ret_ready;
    logic       frv;
    logic       drop;
  } ctl_t;

  ctl_t          ctl_q[$];
  alloc_t        alloc_sb[$];
  logic [TW-1:0] ret_sb[$];
  logic [TW-1:0] rq[$];
  int            cyc = 0;
  int            last_g = NUM_REQ - 1;
  logic          drop_flag = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the reference model is updated and its
  // expectations queued before the edge.
  task automatic step(input logic [1:0] rv, input logic stall, input logic frv_in,
                      input logic [TW-1:0] ftag, input logic sv, input logic [TW-1:0] stag,
                      input logic rtv, input logic [TW-1:0] rtag, input logic full,
                      input logic r);
    ctl_t   e;
    alloc_t a;
    int     g;
    rst = r; req_valid = rv; alloc_stall = stall; fl_read_valid = frv_in;
    fl_read_tag = ftag; squash_valid = sv; squash_tag = stag;
    retire_valid = rtv; retire_tag = rtag; fl_full = full;

    g = -1;
    if (!r && !stall && frv_in)
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && rv[(last_g + 1 + k) % NUM_REQ]) g = (last_g + 1 + k) % NUM_REQ;
    e.grant   = (g < 0) ? 2'b00 : 2'(1 << g);
    e.fl_read = (g >= 0);
    if (g >= 0) begin
      last_g = g;
      a.cyc = cyc + 1; a.av = e.grant; a.tag = ftag;
      alloc_sb.push_back(a);
    end
    e.ret_ready = (DEPTH - rq.size()) >= 2;
    e.frv       = !r && rq.size() != 0 && !full;
    e.drop      = drop_flag;
    ctl_q.push_back(e);

    if (r) begin
      rq.delete(); ret_sb.delete(); drop_flag = 1'b0; last_g = NUM_REQ - 1;
    end else begin
      if (e.frv) void'(rq.pop_front());
      if (e.ret_ready) begin
        if (sv)  begin rq.push_back(stag); ret_sb.push_back(stag); end
        if (rtv) begin rq.push_back(rtag); ret_sb.push_back(rtag); end
      end else if (sv || rtv) drop_flag = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input logic full);
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, full, 1'b0);
  endtask

  // Monitor: control outputs every cycle, tags only when the DUT presents them.
  initial begin
    ctl_t   e;
    alloc_t a;
    forever begin
      @(negedge clk);
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        chk("grant",     32'(grant),           32'(e.grant));
        chk("fl_read",   32'(fl_read),         32'(e.fl_read));
        chk("ret_ready", 32'(ret_ready),       32'(e.ret_ready));
        chk("fl_return_valid", 32'(fl_return_valid), 32'(e.frv));
        chk("drop_err",  32'(drop_err),        32'(e.drop));
        if (alloc_sb.size() > 0 && alloc_sb[0].cyc == cyc) begin
          a = alloc_sb.pop_front();
          chk("alloc_valid", 32'(alloc_valid), 32'(a.av));
          chk("alloc_tag",   32'(alloc_tag),   32'(a.tag));
        end else begin
          chk("alloc_idle", 32'(alloc_valid), 32'd0);
        end
        if (fl_return_valid === 1'b1) begin
          if (ret_sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL ret_unexpected cyc=%0d got tag=%0h expected no return", cyc, fl_return_tag);
          end else begin
            chk("ret_tag", 32'(fl_return_tag), 32'(ret_sb.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; alloc_stall = 1'b0; fl_read_valid = 1'b0;
    fl_read_tag = '0; squash_valid = 1'b0; squash_tag = '0;
    retire_valid = 1'b0; retire_tag = '0; fl_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Post-reset idle state.
    idle(1'b0);
    // Two contenders alternate, tags 32..35.
    for (int k = 0; k < 4; k++)
      step(2'b11, 1'b0, 1'b1, 6'(32 + k), 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    // Empty free list, then stall: no grant.
    step(2'b01, 1'b0, 1'b0, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b1, 6'd6, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    // Same-cycle squash 40 / retire 41.
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b1, 6'd40, 1'b1, 6'd41, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    // Fill to 3 with free list full, one dropped release, then drain.
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b1, 6'd10, 1'b0, 6'd0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 6'd11, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b1, 6'd12, 1'b0, 6'd0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b1, 6'd13, 1'b0, 6'd0, 1'b1, 1'b0);
    idle(1'b1);
    repeat (4) idle(1'b0);
    // Two queued entries plus a grant to 0, then reset: queue and priority cleared.
    step(2'b01, 1'b0, 1'b1, 6'd20, 1'b1, 6'd21, 1'b1, 6'd22, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    step(2'b11, 1'b0, 1'b1, 6'd23, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    idle(1'b0);
    // Randomized traffic.
    for (int n = 0; n < 1500; n++)
      step(2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
           6'($urandom), $urandom_range(0, 2) == 0, 6'($urandom),
           $urandom_range(0, 2) == 0, 6'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    repeat (8) idle(1'b0);
    @(negedge clk);
    chk("ret_sb_drained", 32'(ret_sb.size()), 32'd0);
    chk("alloc_sb_drained", 32'(alloc_sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 2: number of rename allocation requesters.
REQ-002 Parameter TAG_WIDTH, default 6: physical register tag width.
REQ-003 Parameter RQ_DEPTH, default 4: return-queue entries; power of two, >= 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester allocation request.
REQ-007 alloc_stall  input  1  when high, no grant is issued.
REQ-008 grant  output  NUM_REQ  one-hot combinational grant, this cycle.
REQ-009 alloc_valid  output  NUM_REQ  registered one-hot: tag delivered to requester i.
REQ-010 alloc_tag  output  TAG_WIDTH  registered tag accompanying alloc_valid.
REQ-011 fl_read  output  1  pop strobe to the free list.
REQ-012 fl_read_tag  input  TAG_WIDTH  free-list head tag.
REQ-013 fl_read_valid  input  1  free list non-empty.
REQ-014 retire_valid / retire_tag  input  1 / TAG_WIDTH  commit-side tag release.
REQ-015 squash_valid / squash_tag  input  1 / TAG_WIDTH  flush-side tag release.
REQ-016 ret_ready  output  1  both release ports may present a tag this cycle.
REQ-017 fl_return_valid / fl_return_tag  output  1 / TAG_WIDTH  push to the free list.
REQ-018 fl_full  input  1  free list full; blocks fl_return_valid.
REQ-019 drop_err  output  1  sticky: a release was presented while ret_ready was low.

Function
REQ-020 Grant eligibility: req_valid[i] high, alloc_stall low, fl_read_valid high, rst low.
- At most one grant per cycle.
REQ-021 Arbitration shall be round-robin over eligible requesters.
- Search starts at the index after the last granted one.
- Priority pointer resets to 0 (requester 0 highest after reset).
- Pointer advances only on a grant.
REQ-022 fl_read shall equal OR of grant, asserted in the same cycle.
REQ-023 On a grant to i in cycle N:
- alloc_valid = one-hot i and alloc_tag = fl_read_tag sampled in N, both in cycle N+1.
- alloc_valid is low in any cycle following a no-grant cycle.
REQ-024 A requester with req_valid held high and no competition is granted every cycle (throughput 1 tag/cycle).
REQ-025 Return queue: FIFO of RQ_DEPTH tags; wrap-around pointers plus a count of width clog2(RQ_DEPTH)+1.
REQ-026 ret_ready = (RQ_DEPTH - count) >= 2, from registered count only; a same-cycle dequeue is not credited.
REQ-027 Enqueue occurs only when ret_ready is high; 0, 1 or 2 entries per cycle.
- If both release ports are valid in the same cycle, squash_tag is enqueued before retire_tag.
REQ-028 Head dequeue: fl_return_valid = (count != 0) && !fl_full, fl_return_tag = head entry.
- Pop occurs when fl_return_valid is high.
- Minimum release-to-return latency is 1 cycle; no bypass.
REQ-029 Simultaneous enqueue and dequeue: count_next = count + enq - deq; FIFO order preserved.
REQ-030 A release port valid while ret_ready is low shall be dropped (not enqueued) and set drop_err; drop_err clears only on rst.
REQ-031 The allocation and return paths are independent; neither stalls the other.

Reset
REQ-032 With rst high at a clock edge, the following clear:
- alloc_valid, drop_err, return-queue pointers/count, and RR pointer.
- grant, fl_read, fl_return_valid held low during rst.
REQ-033 rst mid-operation discards queued returns and any in-flight alloc_valid; the first grant may occur in the first cycle with rst low.

Verification
REQ-034 Both req_valid high for 4 cycles, fl_read_valid=1, tags 32,33,34,35 -> grants 0,1,0,1; alloc_valid 01,10,01,10 one cycle later with alloc_tag 32..35.
REQ-035 req_valid=1 with fl_read_valid=0 or alloc_stall=1 -> grant=0, fl_read=0, alloc_valid=0 next cycle.
REQ-036 squash_tag=40 and retire_tag=41 in the same cycle, fl_full=0 -> fl_return_tag 40 then 41 on consecutive cycles, starting 1 cycle later.
REQ-037 fl_full=1 with 3 releases, RQ_DEPTH=4 -> count reaches 3, ret_ready=0, no fl_return_valid; further release sets drop_err; fl_full=0 drains 3 tags in order.
REQ-038 Queue holding 2 entries with fl_full=0, rst pulsed 1 cycle -> fl_return_valid=0 and count=0 next cycle; grant to requester 0 on the first post-reset request.
